pool_relu_stream: RTL and testbench
===================================

POOL_RELU_STREAM -- requirements
Module: pool_relu_stream

Interface
REQ-001 Parameter: RELU_EN, default 1, meaning 1 = clamp negatives to 0 before pooling, 0 = pool raw signed values.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_st  input  1  one-cycle strobe from the upstream convolution stage; din is valid in that cycle.
REQ-005 Port: din  input  576  6x6 signed 16-bit convolution results; element [r][c] at din[(r*6+c)*16 +: 16].
REQ-006 Port: dout  output  16  signed pooled result, registered.
REQ-007 Port: dout_valid  output  1  dout holds a valid pooled value.
REQ-008 Port: dout_ready  input  1  downstream accepts dout this cycle.
REQ-009 Port: dout_last  output  1  high with the 9th (final) pooled value of a frame.
REQ-010 Port: busy  output  1  high while a frame is held or being streamed; in_st is ignored while high.
REQ-011 Port: overflow  output  1  sticky flag; an in_st arrived while busy and the frame was dropped.

Function
REQ-012 States: IDLE and STREAM only; busy SHALL equal (state == STREAM).
REQ-013 IDLE with in_st=1: capture all 36 din elements into internal registers, clear the index k to 0, and enter STREAM on the same edge.
REQ-014 IDLE with in_st=0: hold state; dout_valid=0, dout_last=0.
REQ-015 In STREAM, dout_valid SHALL be 1; the first valid value appears the cycle after the capture edge, giving 1-cycle latency.
REQ-016 Pooled value k (0..8): pr=k/3, pc=k%3; dout = max over a,b in {0,1} of f(conv[2pr+a][2pc+b]).
REQ-017 f(x) = (x<0 ? 0 : x) when RELU_EN=1; f(x) = x when RELU_EN=0; max is a signed comparison; dout stays 16 bits with no widening or saturation.
REQ-018 Output order: row-major, k=0..8.
REQ-019 A transfer occurs on a rising edge with dout_valid=1 and dout_ready=1.
REQ-020 On a transfer, k increments and dout updates to value k+1 on the same edge.
REQ-021 While dout_valid=1 and dout_ready=0, dout, dout_last and k SHALL hold stable.
REQ-022 dout_last SHALL be 1 exactly when dout_valid=1 and k=8.
REQ-023 A transfer with k=8 returns to IDLE on the same edge; dout_valid=0 on the next cycle.
REQ-024 in_st while busy=1, including the cycle of the final transfer, drops that frame and sets overflow=1; the frame in progress is unaffected.
REQ-025 overflow SHALL remain 1 until reset.
REQ-026 din is sampled only on the accepting in_st edge; later din changes do not affect the frame in progress.
REQ-027 dout_ready is ignored while dout_valid=0.

Reset
REQ-028 reset=1 at a rising edge forces state=IDLE, k=0, dout=0, dout_valid=0, dout_last=0, busy=0, overflow=0, and all 36 captured registers = 0.
REQ-029 Reset has priority over in_st and over a transfer in the same cycle.
REQ-030 Reset mid-STREAM aborts the frame; no further values of that frame are output.
REQ-031 The first cycle after reset deasserts accepts an in_st normally.

Verification
REQ-032 Scenario: RELU_EN=1, conv[r][c]=r*6+c, dout_ready=1 throughout, one in_st -> from the next cycle, 9 consecutive valid beats 7,9,11,19,21,23,31,33,35; dout_last only on beat 9; busy low afterwards.
REQ-033 Scenario: RELU_EN=1, all conv=-5 -> 9 beats of 0; the same frame with RELU_EN=0 -> 9 beats of -5 (0xFFFB).
REQ-034 Scenario: backpressure with dout_ready toggling 1,0,0,1,... -> values and order identical to REQ-032; dout held stable across every stall; 9 transfers total.
REQ-035 Scenario: second in_st at stream beat 4 and a third in_st coincident with the final transfer -> both frames dropped; overflow=1 and stays 1; original 9 values unchanged.
REQ-036 Scenario: reset asserted after 3 transfers -> next cycle dout_valid=0, dout=0, overflow=0; new in_st two cycles later -> full 9-beat frame from k=0.
REQ-037 Scenario: boundary values, conv[0][0]=32767 and conv[0][1]=-32768, rest 0, RELU_EN=0 -> beat 0 = 32767; remaining beats = 0.

Source files
------------

// File: rtl/pool_relu_stream.sv
// 6x6 convolution tile -> optional ReLU -> 2x2/stride-2 max pool, streamed out
// as nine row-major values over a valid/ready handshake.
module pool_relu_stream #(
  parameter int RELU_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_st,
  input  logic [575:0] din,
  output logic [15:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         overflow
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [575:0]   conv_q, conv_d;
  logic [15:0]    dout_q, dout_d;
  logic           ovf_q, ovf_d;

  function automatic logic signed [15:0] act(input logic signed [15:0] x);
    if ((RELU_EN != 0) && (x < 0)) return 16'sd0;
    return x;
  endfunction

  // Max of the 2x2 window feeding pooled output k (pr = k/3, pc = k%3).
  function automatic logic [15:0] pool_win(input logic [575:0] arr, input logic [3:0] k);
    int pr, pc, idx;
    logic signed [15:0] best, cand;
    pr   = int'(k) / 3;
    pc   = int'(k) % 3;
    best = 16'sd0;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        idx  = ((2 * pr + a) * 6 + 2 * pc + b) * 16;
        cand = act(arr[idx +: 16]);
        if (((a == 0) && (b == 0)) || (cand > best)) best = cand;
      end
    end
    return best;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    conv_d  = conv_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_st) begin
          conv_d  = din;
          k_d     = 4'd0;
          dout_d  = pool_win(din, 4'd0);
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (in_st) ovf_d = 1'b1;
        if (dout_ready) begin
          if (k_q == 4'd8) begin
            // dout keeps the final value; only dout_valid drops.
            k_d     = 4'd0;
            state_d = S_IDLE;
          end else begin
            k_d    = k_q + 4'd1;
            dout_d = pool_win(conv_q, k_q + 4'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      conv_q  <= '0;
      dout_q  <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      conv_q  <= conv_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == S_STREAM);
  assign dout_last  = (state_q == S_STREAM) && (k_q == 4'd8);
  assign busy       = (state_q == S_STREAM);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pool_relu_stream.sv
// Directed bench for pool_relu_stream: one ReLU instance and one raw instance
// share stimulus; expected beats are hand-computed per scenario.
module tb_pool_relu_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_st;
  logic [575:0] din;
  logic         dout_ready;
  logic [15:0]  dout1, dout0;
  logic         valid1, valid0, last1, last0, busy1, busy0, ovf1, ovf0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]  exp1 [9];
  logic [15:0]  exp0 [9];
  logic [575:0] frame_v;

  always #5 clk = ~clk;

  pool_relu_stream #(.RELU_EN(1)) u_relu (
    .clk(clk), .reset(reset), .in_st(in_st), .din(din),
    .dout(dout1), .dout_valid(valid1), .dout_ready(dout_ready),
    .dout_last(last1), .busy(busy1), .overflow(ovf1)
  );

  pool_relu_stream #(.RELU_EN(0)) u_raw (
    .clk(clk), .reset(reset), .in_st(in_st), .din(din),
    .dout(dout0), .dout_valid(valid0), .dout_ready(dout_ready),
    .dout_last(last0), .busy(busy0), .overflow(ovf0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse in_st with frame_v; returns in the first cycle dout_valid should be high.
  task automatic send_frame();
    din   = frame_v;
    in_st = 1'b1;
    step();
    in_st = 1'b0;
  endtask

  // rmode 0: ready always high; rmode 1: ready pattern 1,0,0 repeating.
  // inject: extra in_st at beat 4 and coincident with the final transfer.
  task automatic stream_check(input string tag, input int rmode, input bit inject);
    int idx = 0;
    int c = 0;
    bit stalled = 1'b0;
    bit inj4 = 1'b0;
    logic [15:0] held1 = 16'd0;
    logic [15:0] held0 = 16'd0;
    while (idx < 9 && c < 60) begin
      check({tag, " valid"}, {31'd0, valid1}, 32'd1);
      check({tag, " busy"}, {31'd0, busy1}, {31'd0, valid1});
      if (stalled) begin
        check({tag, " hold relu"}, {16'd0, dout1}, {16'd0, held1});
        check({tag, " hold raw"}, {16'd0, dout0}, {16'd0, held0});
      end
      dout_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
      if (inject && ((idx == 4 && !inj4) || (idx == 8 && dout_ready))) begin
        if (idx == 4) inj4 = 1'b1;
        in_st = 1'b1;
        din   = ~frame_v;
      end
      check({tag, " last"}, {31'd0, last1}, {31'd0, (idx == 8)});
      if (dout_ready) begin
        check({tag, " beat relu"}, {16'd0, dout1}, {16'd0, exp1[idx]});
        check({tag, " beat raw"}, {16'd0, dout0}, {16'd0, exp0[idx]});
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held1 = dout1;
        held0 = dout0;
      end
      step();
      in_st = 1'b0;
      c++;
    end
    if (idx < 9) check({tag, " timeout beats"}, idx, 9);
    dout_ready = 1'b0;
    check({tag, " idle valid"}, {31'd0, valid1}, 32'd0);
    check({tag, " idle busy"}, {31'd0, busy1}, 32'd0);
    check({tag, " idle busy raw"}, {31'd0, busy0}, 32'd0);
  endtask

  task automatic set_ramp_exp();
    logic [15:0] v [9];
    v = '{16'd7, 16'd9, 16'd11, 16'd19, 16'd21, 16'd23, 16'd31, 16'd33, 16'd35};
    for (int i = 0; i < 36; i++) frame_v[i*16 +: 16] = 16'(i);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = v[i];
      exp0[i] = v[i];
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_st      = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 36; i++) frame_v[i*16 +: 16] = 16'(i);
    din = frame_v;
    step();
    step();
    // in_st was high alongside reset: reset must win
    check("rst valid", {31'd0, valid1}, 32'd0);
    check("rst busy", {31'd0, busy1}, 32'd0);
    check("rst dout", {16'd0, dout1}, 32'd0);
    check("rst last", {31'd0, last1}, 32'd0);
    check("rst ovf", {31'd0, ovf1}, 32'd0);
    in_st = 1'b0;

    // Ramp frame, accepted in the first cycle after reset deasserts
    set_ramp_exp();
    reset = 1'b0;
    send_frame();
    stream_check("ramp", 0, 1'b0);
    check("ramp ovf", {31'd0, ovf1}, 32'd0);

    // All -5
    for (int i = 0; i < 36; i++) frame_v[i*16 +: 16] = 16'hFFFB;
    for (int i = 0; i < 9; i++) begin
      exp1[i] = 16'd0;
      exp0[i] = 16'hFFFB;
    end
    step();
    send_frame();
    stream_check("neg5", 0, 1'b0);

    // Boundary values
    frame_v = '0;
    frame_v[0 +: 16]  = 16'h7FFF;
    frame_v[16 +: 16] = 16'h8000;
    for (int i = 0; i < 9; i++) begin
      exp1[i] = 16'd0;
      exp0[i] = 16'd0;
    end
    exp1[0] = 16'h7FFF;
    exp0[0] = 16'h7FFF;
    send_frame();
    stream_check("bound", 0, 1'b0);

    // Backpressure
    set_ramp_exp();
    step();
    send_frame();
    dout_ready = 1'b0;
    step();
    check("bp stall hold", {16'd0, dout1}, 32'd7);
    check("bp stall k0 last", {31'd0, last1}, 32'd0);
    stream_check("bp", 1, 1'b0);

    // Overflow: in_st at beat 4 and at the final transfer
    send_frame();
    stream_check("ovf", 1, 1'b1);
    check("ovf flag relu", {31'd0, ovf1}, 32'd1);
    check("ovf flag raw", {31'd0, ovf0}, 32'd1);
    step();
    step();
    check("ovf sticky", {31'd0, ovf1}, 32'd1);
    check("ovf no restart", {31'd0, valid1}, 32'd0);

    // Reset after 3 transfers
    send_frame();
    dout_ready = 1'b1;
    step();
    step();
    step();
    check("mid beat3", {16'd0, dout1}, 32'd19);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid rst valid", {31'd0, valid1}, 32'd0);
    check("mid rst dout", {16'd0, dout1}, 32'd0);
    check("mid rst ovf", {31'd0, ovf1}, 32'd0);
    step();
    check("mid abort", {31'd0, valid1}, 32'd0);
    send_frame();
    stream_check("after rst", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
